door_input_conditioner: RTL and testbench
=========================================

Name: door_input_conditioner

Overview:
- Upstream front end for the door-control FSM.
- Takes the four raw, asynchronous door inputs from ui pins: presence sensor, emergency/stop, open limit switch, close limit switch.
- Synchronises and debounces each input, then presents clean levels to the FSM.
- Also provides one-cycle rising-edge strobes and a sticky fault flag for the illegal "both limit switches active" condition.

Parameters:
- N_CH, 4, number of conditioned channels.
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel; legal range is 2 or more.
- DB_CYCLES, 16, consecutive stable cycles required before a clean level changes; legal range is 2 or more.
- CNT_W, $clog2(DB_CYCLES), debounce counter width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  tile enable; 0 freezes debounce state.
- raw_in  input  N_CH  raw pins: bit0 Sen, bit1 SE, bit2 LA, bit3 LC.
- fault_clr  input  1  synchronous clear of the sticky fault.
- clean_out  output  N_CH  debounced levels, same bit order; feeds the FSM inputs.
- rise_pulse  output  N_CH  one-cycle strobe when clean_out[i] rises.
- fault  output  1  sticky; LA and LC both clean-high were seen together.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All synchroniser flops, debounce counters, clean_out, rise_pulse and fault go to 0.
  - Release is synchronous to clk; no outputs change on the release edge itself.
- Synchroniser:
  - Each raw_in[i] passes through a SYNC_STAGES flop chain. s[i] is the last stage.
  - The chain always runs, independent of ena.
- Debounce, per channel, evaluated each clk edge when ena=1:
  - If s[i] equals clean_out[i], the counter is cleared to 0.
  - If s[i] differs and the counter is below DB_CYCLES-1, the counter increments.
  - If s[i] differs and the counter equals DB_CYCLES-1, clean_out[i] becomes s[i] and the counter clears.
  - Result: a change needs DB_CYCLES consecutive differing samples. A glitch shorter than that leaves clean_out unchanged and restarts the count.
- Latency: if edge k is the first clk edge to sample a new stable raw level, clean_out changes at edge k+(SYNC_STAGES-1)+DB_CYCLES. With the defaults that is edge k+17.
- rise_pulse[i]: registered; high for exactly the one cycle following the edge where clean_out[i] went 0->1. Falling edges produce no pulse.
- ena=0:
  - Counters and clean_out hold their values.
  - rise_pulse is forced to 0.
  - fault holds, but fault_clr is still honoured.
  - When ena returns to 1, counting resumes from the held count.
- fault:
  - Set at the edge after clean_out[2] and clean_out[3] are both 1.
  - Stays 1 until a fault_clr edge with the condition false.
  - Simultaneous set condition and fault_clr: set wins, fault stays 1.
- Counter saturation: the counter never exceeds DB_CYCLES-1; there is no wrap.
- Reset mid-count: all state returns to 0 immediately. A channel whose raw pin is held at 1 is re-qualified from scratch after release, with full latency.
- All channels are independent; simultaneous transitions on several channels each follow their own timing.

Decomposition:
- Shared package door_pkg holds:
  - Channel index constants: CH_SEN=0, CH_SE=1, CH_LA=2, CH_LC=3.
  - N_CH default.
  - DB_CYCLES default.
  - The FSM consumes the same index constants.
- Sub-module debounce_ch holds one channel's synchroniser, counter, clean level and rise strobe. It is parameterised by SYNC_STAGES and DB_CYCLES.
- The top instantiates N_CH copies in a generate loop and adds the fault logic.

Test Plan:
1. Reset, then hold raw_in=4'b0000 for 50 cycles with ena=1. Required: clean_out=0, rise_pulse=0, fault=0 throughout.
2. Raise raw_in[0] just before edge k and hold it. Required: clean_out[0] rises at edge k+17; rise_pulse[0]=1 only for the cycle after k+17; other bits stay 0.
3. Pulse raw_in[2] high for 10 cycles, low, then high for 15 cycles. Required: clean_out[2] never changes and rise_pulse[2] stays 0.
4. Hold raw_in[3] high; at cycle 8 of qualification drop ena for 5 cycles, then restore it. Required: the counter holds during the gap and clean_out[3] rises 5 cycles later than in scenario 2, i.e. at k+22.
5. Qualify LA and LC high together. Required: fault=1 one edge after both clean bits are 1. Assert fault_clr while both are still high: fault stays 1. Drop LC, wait for clean_out[3]=0, pulse fault_clr: fault=0 next edge.
6. With clean_out[1]=1 (SE qualified), assert rst_n=0 mid-cycle, keep raw_in[1]=1, and release. Required: clean_out[1]=0 immediately on reset, returns to 1 at 17 edges after release, and rise_pulse[1] fires once.

Source files
------------

// File: rtl/door_pkg.sv
// Shared definitions for the door input front end and the door-control FSM.
package door_pkg;

    // Bit positions of each door input within raw_in / clean_out / rise_pulse.
    localparam int CH_SEN = 0;  // presence sensor
    localparam int CH_SE  = 1;  // emergency / stop
    localparam int CH_LA  = 2;  // open limit switch
    localparam int CH_LC  = 3;  // close limit switch

    // Default sizing for the conditioner.
    localparam int N_CH_DEFAULT        = 4;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DB_CYCLES_DEFAULT   = 16;

endpackage

// File: rtl/debounce_ch.sv
// One conditioned channel: synchroniser chain, debounce counter,
// clean level and a registered rising-edge strobe.
module debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic raw_in,
    output logic clean_out,
    output logic rise_pulse
);

    localparam int                CNT_W  = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clean_q, clean_d;
    logic                   rise_q, rise_d;
    logic                   s_bit;

    // Last synchroniser stage is the level the debouncer looks at.
    assign s_bit = sync_q[SYNC_STAGES-1];

    // Synchroniser shifts every cycle regardless of ena; debounce only when enabled.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        if (ena) begin
            if (s_bit == clean_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
                // DB_CYCLES consecutive differing samples: accept the new level.
                clean_d = s_bit;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            rise_d = clean_d & ~clean_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
        end
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/door_input_conditioner.sv
// Door input front end: per-channel synchronise/debounce plus a sticky
// fault for both limit switches reading active at once.
module door_input_conditioner
    import door_pkg::*;
#(
    parameter int N_CH        = N_CH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] raw_in,
    input  logic            fault_clr,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic            fault
);

    logic fault_q, fault_d;
    logic limits_both;

    // Independent conditioner per door input.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .DB_CYCLES   (DB_CYCLES)
            ) u_ch (
                .clk        (clk),
                .rst_n      (rst_n),
                .ena        (ena),
                .raw_in     (raw_in[gi]),
                .clean_out  (clean_out[gi]),
                .rise_pulse (rise_pulse[gi])
            );
        end
    endgenerate

    assign limits_both = clean_out[CH_LA] & clean_out[CH_LC];

    // Sticky fault: the set condition beats a concurrent clear; clear works even when disabled.
    always_comb begin
        fault_d = fault_q;
        if (ena && limits_both) begin
            fault_d = 1'b1;
        end else if (fault_clr && !limits_both) begin
            fault_d = 1'b0;
        end
    end

    // Fault register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

endmodule

// File: tb/tb_door_input_conditioner.sv
// Directed bench for door_input_conditioner with hand-computed timing.
`timescale 1ns/1ps
module tb_door_input_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] raw_in;
    logic       fault_clr;
    logic [3:0] clean_out;
    logic [3:0] rise_pulse;
    logic       fault;

    int total_cnt;
    int bad_cnt;

    door_input_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .raw_in     (raw_in),
        .fault_clr  (fault_clr),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check clean/rise/fault together as one 9-bit word.
    task automatic check_all(input string tag, input logic [3:0] c, input logic [3:0] r, input logic f);
        check(tag, {7'd0, clean_out, rise_pulse, fault}, {7'd0, c, r, f});
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n     = 1'b0;
        ena       = 1'b0;
        raw_in    = 4'b0000;
        fault_clr = 1'b0;

        // Reset state
        #23;
        check_all("reset", 4'b0000, 4'b0000, 1'b0);
        tick();
        rst_n = 1'b1;
        check_all("release", 4'b0000, 4'b0000, 1'b0);

        // 1: idle inputs, everything stays quiet
        ena = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_all("idle", 4'b0000, 4'b0000, 1'b0);
        end

        // 2: presence sensor qualifies at edge k+17
        raw_in[0] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_all("sen_wait", 4'b0000, 4'b0000, 1'b0);
        end
        tick();
        check_all("sen_rise", 4'b0001, 4'b0001, 1'b0);
        tick();
        check_all("sen_after", 4'b0001, 4'b0000, 1'b0);

        // 3: LA glitches of 10 and 15 cycles never qualify
        raw_in[2] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("la_glitch10", 4'b0001, 4'b0000, 1'b0);
        end
        raw_in[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("la_gap", 4'b0001, 4'b0000, 1'b0);
        end
        raw_in[2] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_all("la_glitch15", 4'b0001, 4'b0000, 1'b0);
        end
        raw_in[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("la_settle", 4'b0001, 4'b0000, 1'b0);
        end

        // 4: LC qualification with a 5-cycle enable gap, rises at k+22
        raw_in[3] = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            if (i == 9)  ena = 1'b0;
            if (i == 14) ena = 1'b1;
            tick();
            check_all("lc_wait", 4'b0001, 4'b0000, 1'b0);
        end
        tick();
        check_all("lc_rise", 4'b1001, 4'b1000, 1'b0);
        tick();
        check_all("lc_after", 4'b1001, 4'b0000, 1'b0);

        // 5: LA joins LC -> fault one edge later
        raw_in[2] = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_all("la_wait", 4'b1001, 4'b0000, 1'b0);
        end
        tick();
        check_all("both_clean", 4'b1101, 4'b0100, 1'b0);
        tick();
        check_all("fault_set", 4'b1101, 4'b0000, 1'b1);
        fault_clr = 1'b1;
        tick();
        check_all("clr_blocked", 4'b1101, 4'b0000, 1'b1);
        fault_clr = 1'b0;
        raw_in[3] = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_all("lc_fall_wait", 4'b1101, 4'b0000, 1'b1);
        end
        tick();
        check_all("lc_fall", 4'b0101, 4'b0000, 1'b1);
        fault_clr = 1'b1;
        tick();
        check_all("fault_clr", 4'b0101, 4'b0000, 1'b0);
        fault_clr = 1'b0;
        tick();
        check_all("fault_stay0", 4'b0101, 4'b0000, 1'b0);

        // 6: SE qualifies, then asynchronous reset mid-cycle with pins held
        raw_in[1] = 1'b1;
        for (int i = 1; i <= 17; i++) tick();
        tick();
        check_all("se_rise", 4'b0111, 4'b0010, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 4'b0000, 4'b0000, 1'b0);
        tick();
        check_all("rst_hold", 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_all("requal_wait", 4'b0000, 4'b0000, 1'b0);
        end
        tick();
        check_all("requal_rise", 4'b0111, 4'b0111, 1'b0);
        tick();
        check_all("requal_after", 4'b0111, 4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
